rcu_wdt_core: RTL and testbench

Watchdog timer core that sits directly upstream of the reset and clock unit and drives its `wdt_rst_n_i` input. It counts down a programmable reload value at a prescaled rate. It raises an optional early-warning interrupt, and it emits a fixed-length active-low reset pulse on timeout or on an invalid feed. Once enabled it is locked: only `rst_i` or its own reset pulse can return it to idle.

---
 rtl/rcu_wdt_core.sv | 177 +++++++++++++++++
 tb/tb_rcu_wdt_core.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rcu_wdt_core.sv
`default_nettype none
// ============================================================================
// Module      : rcu_wdt_core
// Description : Watchdog timer core that drives the active-low reset request
//               of the reset and clock unit. It counts a reload value down at
//               a prescaled rate and raises an optional early-warning
//               interrupt. It emits a fixed-length reset pulse on timeout or
//               on a feed with the wrong key. Once it is armed, only rst_i or
//               its own reset pulse returns it to idle.
// Options     : RCU_WDT_WARN_IRQ_EN - enables the WARN state and irq_o.
//               When it is undefined, irq_o stays 0 and WARN is never entered.
// Revision    : 1.0 - initial release
// ============================================================================
module rcu_wdt_core #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned PSC_WIDTH = 8,
    parameter int unsigned RST_PULSE = 16,
    parameter logic [15:0] FEED_KEY  = 16'h5AA5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] load_i,
    input  logic [PSC_WIDTH-1:0] psc_i,
    input  logic [CNT_WIDTH-1:0] warn_thr_i,
    input  logic                 feed_valid_i,
    input  logic [15:0]          feed_key_i,
    output logic                 irq_o,
    output logic                 wdt_rst_n_o,
    output logic [1:0]           cause_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic [1:0]           state_o
);

`ifdef RCU_WDT_WARN_IRQ_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif

    // The hold counter only has to reach RST_PULSE-1.
    localparam int unsigned     HOLD_W    = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_PULSE - 1);

    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_BADKEY  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WARN = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PSC_WIDTH-1:0]  psc_q, psc_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  irq_q, irq_d;
    logic                  rst_n_q, rst_n_d;
    logic [1:0]            cause_q, cause_d;

    logic                  key_match;
    logic                  feed_ok;
    logic                  feed_bad;
    logic                  tick;
    logic [CNT_WIDTH-1:0]  cnt_dec;

    assign key_match = (feed_key_i == FEED_KEY);
    assign feed_ok   = feed_valid_i &&  key_match;
    assign feed_bad  = feed_valid_i && !key_match;
    assign tick      = (psc_q == psc_i);
    assign cnt_dec   = cnt_q - CNT_WIDTH'(1);

    // State register and all datapath registers, with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            psc_q   <= '0;
            hold_q  <= '0;
            irq_q   <= 1'b0;
            rst_n_q <= 1'b1;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            psc_q   <= psc_d;
            hold_q  <= hold_d;
            irq_q   <= irq_d;
            rst_n_q <= rst_n_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic. An invalid feed has priority over a valid feed, and a
    // valid feed has priority over a tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        psc_d   = psc_q;
        hold_d  = hold_q;
        irq_d   = irq_q;
        rst_n_d = rst_n_q;
        cause_d = cause_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = load_i;
                psc_d   = '0;
                hold_d  = '0;
                irq_d   = 1'b0;
                rst_n_d = 1'b1;
                if (en_i) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_WARN: begin
                if (feed_bad) begin
                    state_d = ST_HOLD;
                    rst_n_d = 1'b0;
                    cause_d = CAUSE_BADKEY;
                    irq_d   = 1'b0;
                    hold_d  = '0;
                end else if (feed_ok) begin
                    state_d = ST_RUN;
                    cnt_d   = load_i;
                    psc_d   = '0;
                    irq_d   = 1'b0;
                end else if (tick) begin
                    psc_d = '0;
                    if (cnt_q == '0) begin
                        state_d = ST_HOLD;
                        rst_n_d = 1'b0;
                        cause_d = CAUSE_TIMEOUT;
                        irq_d   = 1'b0;
                        hold_d  = '0;
                    end else begin
                        cnt_d = cnt_dec;
                        if (WARN_EN && (state_q == ST_RUN) && (cnt_dec <= warn_thr_i)) begin
                            state_d = ST_WARN;
                            irq_d   = 1'b1;
                        end
                    end
                end else begin
                    psc_d = psc_q + PSC_WIDTH'(1);
                end
            end

            ST_HOLD: begin
                // The count stays frozen. The pulse ends when the state
                // returns to IDLE.
                irq_d = 1'b0;
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    rst_n_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign irq_o       = irq_q;
    assign wdt_rst_n_o = rst_n_q;
    assign cause_o     = cause_q;
    assign cnt_o       = cnt_q;
    assign state_o     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rcu_wdt_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_rcu_wdt_core
// Description : Directed testbench for rcu_wdt_core. Expected values are
//               worked out by hand from the watchdog timing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rcu_wdt_core;

    localparam int unsigned CNT_WIDTH = 32;
    localparam int unsigned PSC_WIDTH = 8;

    logic                 clk_i;
    logic                 rst_i;
    logic                 en_i;
    logic [CNT_WIDTH-1:0] load_i;
    logic [PSC_WIDTH-1:0] psc_i;
    logic [CNT_WIDTH-1:0] warn_thr_i;
    logic                 feed_valid_i;
    logic [15:0]          feed_key_i;
    logic                 irq_o;
    logic                 wdt_rst_n_o;
    logic [1:0]           cause_o;
    logic [CNT_WIDTH-1:0] cnt_o;
    logic [1:0]           state_o;

    int n_checks = 0;
    int n_errors = 0;

    rcu_wdt_core #(
        .CNT_WIDTH (CNT_WIDTH),
        .PSC_WIDTH (PSC_WIDTH),
        .RST_PULSE (16),
        .FEED_KEY  (16'h5AA5)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .load_i       (load_i),
        .psc_i        (psc_i),
        .warn_thr_i   (warn_thr_i),
        .feed_valid_i (feed_valid_i),
        .feed_key_i   (feed_key_i),
        .irq_o        (irq_o),
        .wdt_rst_n_o  (wdt_rst_n_o),
        .cause_o      (cause_o),
        .cnt_o        (cnt_o),
        .state_o      (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Arms the block from IDLE. On return, the RUN entry edge has been taken
    // and en_i has already been released again.
    task automatic start_run(input logic [31:0] ld, input logic [7:0] ps, input logic [31:0] thr);
        load_i     = ld;
        psc_i      = ps;
        warn_thr_i = thr;
        en_i       = 1'b1;
        step(1);
        en_i       = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (state_o == 2'd0) break;
            step(1);
        end
        check("idle_reached", state_o, 2'd0);
    endtask

    initial begin
        rst_i        = 1'b1;
        en_i         = 1'b0;
        load_i       = '0;
        psc_i        = '0;
        warn_thr_i   = '0;
        feed_valid_i = 1'b0;
        feed_key_i   = 16'h0000;
        step(2);
        check("rst_state", state_o, 2'd0);
        check("rst_rstn",  wdt_rst_n_o, 1'b1);
        check("rst_cause", cause_o, 2'b00);
        check("rst_irq",   irq_o, 1'b0);
        check("rst_cnt",   cnt_o, 0);
        rst_i = 1'b0;
        step(1);

        // Timeout with load 3 and psc 1: the pulse falls 8 cycles after RUN
        // entry and lasts 16 cycles. en_i stays high so the block re-arms.
        load_i = 3; psc_i = 1; warn_thr_i = 0; en_i = 1'b1;
        step(1);
        check("to_run_state", state_o, 2'd1);
        check("to_run_cnt",   cnt_o, 3);
        step(7);
        check("to_pre_rstn", wdt_rst_n_o, 1'b1);
        step(1);
        check("to_rstn_fall", wdt_rst_n_o, 1'b0);
        check("to_hold",      state_o, 2'd3);
        check("to_cause",     cause_o, 2'b01);
        check("to_hold_irq",  irq_o, 1'b0);
        step(15);
        check("to_hold_last", wdt_rst_n_o, 1'b0);
        step(1);
        check("to_rstn_rise", wdt_rst_n_o, 1'b1);
        check("to_idle",      state_o, 2'd0);
        step(1);
        check("rearm_state", state_o, 2'd1);
        check("rearm_cnt",   cnt_o, 3);

        // Lowering en_i in RUN has no effect, so the count still times out.
        en_i = 1'b0;
        step(7);
        check("lock_pre_rstn", wdt_rst_n_o, 1'b1);
        check("lock_state",    state_o, 2'd1);
        step(1);
        check("lock_rstn_fall", wdt_rst_n_o, 1'b0);
        check("lock_cause",     cause_o, 2'b01);
        step(16);
        step(1);
        check("lock_stay_idle", state_o, 2'd0);

        // Warning scenario: load 10, psc 0, threshold 4.
        start_run(10, 0, 4);
        check("w_run_cnt", cnt_o, 10);
        step(5);
        check("w_pre_cnt", cnt_o, 5);
        check("w_pre_irq", irq_o, 1'b0);
        step(1);
        check("w_cnt", cnt_o, 4);
`ifdef RCU_WDT_WARN_IRQ_EN
        check("w_irq",   irq_o, 1'b1);
        check("w_state", state_o, 2'd2);
        feed_valid_i = 1'b1; feed_key_i = 16'h5AA5;
        step(1);
        feed_valid_i = 1'b0;
        check("w_feed_irq",   irq_o, 1'b0);
        check("w_feed_cnt",   cnt_o, 10);
        check("w_feed_state", state_o, 2'd1);
`else
        check("w_irq",   irq_o, 1'b0);
        check("w_state", state_o, 2'd1);
        step(4);
        check("w_pre_rstn", wdt_rst_n_o, 1'b1);
        step(1);
        check("w_rstn_fall", wdt_rst_n_o, 1'b0);
        check("w_irq_hold",  irq_o, 1'b0);
`endif
        wait_idle();

        // Wrong key in RUN: the pulse starts at the edge that samples the feed.
        start_run(10, 0, 0);
        step(2);
        check("bad_pre_cnt", cnt_o, 8);
        feed_valid_i = 1'b1; feed_key_i = 16'h1234;
        step(1);
        feed_valid_i = 1'b0;
        check("bad_rstn",  wdt_rst_n_o, 1'b0);
        check("bad_cause", cause_o, 2'b10);
        check("bad_irq",   irq_o, 1'b0);
        check("bad_state", state_o, 2'd3);

        // Asserting rst_i mid-HOLD clears everything on the next edge.
        step(3);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        check("mid_rst_rstn",  wdt_rst_n_o, 1'b1);
        check("mid_rst_cause", cause_o, 2'b00);
        check("mid_rst_state", state_o, 2'd0);

        // A valid feed on the expiring tick wins over the timeout.
        start_run(2, 0, 0);
        step(2);
        check("exp_cnt0", cnt_o, 0);
        feed_valid_i = 1'b1; feed_key_i = 16'h5AA5;
        step(1);
        feed_valid_i = 1'b0;
        check("exp_rstn",  wdt_rst_n_o, 1'b1);
        check("exp_cnt",   cnt_o, 2);
        check("exp_state", state_o, 2'd1);
        check("exp_irq",   irq_o, 1'b0);
        wait_idle();

        // load 0 with psc 2: the reset fires on the first tick, 3 cycles in.
        start_run(0, 2, 0);
        step(2);
        check("z_pre_rstn", wdt_rst_n_o, 1'b1);
        step(1);
        check("z_rstn_fall", wdt_rst_n_o, 1'b0);
        check("z_cause",     cause_o, 2'b01);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
